mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle control FSM that sequences the shared MIPS datapath: PC, IR, register file, ALU and a single unified memory. One instruction takes 3–5 states. Memory states use a ready handshake, so the block stalls on slow memory. Illegal opcodes and memory timeouts halt the core and set an error code.

Parameters:
MEM_WAIT_MAX, 15, maximum stall cycles per memory access before a timeout halt (1..255).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset)
opcode  in  6  IR[31:26]
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
reg_dst  out  1  destination register select: 0 = rt, 1 = rd
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A
alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct
pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
state  out  4  current state (debug)
err  out  2  error code: 00 = none, 01 = illegal opcode, 10 = memory timeout
instr_count  out  CNT_W  number of retired instructions

Behaviour:
- Reset (rst = 0, async): state = FETCH (0), wait counter = 0, err = 00, instr_count = 0. While rst = 0, every control output is forced to 0. FETCH outputs appear in the first cycle after release.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, HALT 12. Codes 13–15 go to HALT with err = 01.
- Outputs are decoded from state. Any output not listed for a state is 0.
- FETCH: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00. ir_write and pc_write are asserted only in the cycle where mem_ready = 1 (Mealy). Goes to DECODE on mem_ready, otherwise stays.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00. Branches on opcode:
  - 000000 → EXEC_R
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDI_EX
  - anything else → HALT with err = 01.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEM_READ for lw, MEM_WRITE for sw. Opcode is re-sampled here; IR is stable.
- MEM_READ: mem_read = 1, i_or_d = 1. Goes to MEM_WB on mem_ready.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Goes to FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Goes to FETCH on mem_ready.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Goes to ALU_WB.
- ALU_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Goes to FETCH.
- JUMP: pc_write = 1, pc_source = 10. Goes to FETCH.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH.
- HALT: all controls 0. Stays until reset. err holds its value and instr_count freezes.
- Stall counter:
  - Counts cycles spent in FETCH, MEM_READ or MEM_WRITE with mem_ready = 0.
  - Clears to 0 on any state change.
  - When it equals MEM_WAIT_MAX and mem_ready = 0: go to HALT, err = 10.
  - If mem_ready = 1 in that same cycle, ready wins and there is no timeout.
- instr_count increments by 1 on each transition into FETCH from any state. It wraps modulo 2^CNT_W.
- Latency with mem_ready always 1:
  - lw: 5 cycles
  - R-type, sw, addi: 4 cycles
  - beq, j: 3 cycles
- Each stall cycle adds one cycle.
- mem_ready is ignored in all states that do not access memory.

Test Plan:
- Release rst, opcode = 100011, mem_ready = 1 → states 0, 1, 2, 3, 4, 0. reg_write = 1 and mem_to_reg = 1 only in state 4. instr_count = 1 after 5 cycles.
- R-type (000000) with mem_ready held 0 for 3 FETCH cycles → FETCH lasts 4 cycles. ir_write and pc_write pulse once, in the 4th cycle. Then states 1, 6, 7, 0.
- beq (000100), then j (000010) → state 8 shows pc_write_cond = 1, alu_op = 01, pc_source = 01. State 9 shows pc_write = 1, pc_source = 10. instr_count = 2.
- opcode = 111111 at DECODE → state = 12 and err = 01 next cycle. All controls stay 0 for 10 cycles. instr_count unchanged.
- MEM_WAIT_MAX = 3, sw, mem_ready = 0 in MEM_WRITE → mem_write high for 4 cycles, then state = 12, err = 10. Repeat with mem_ready = 1 in the 4th cycle → returns to FETCH, err = 00.
- Drive rst = 0 in the middle of MEM_READ, asynchronously between clock edges → outputs go to 0 at once and state = 0. After release, FETCH resumes with instr_count = 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with memory ready handshake,
// stall timeout, illegal-opcode halt and retired-instruction counter.
`default_nettype none

module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait;
  logic [1:0]       r_err;
  logic [1:0]       w_err_next;
  logic [CNT_W-1:0] r_count;
  logic             w_mem_state;

  always_comb begin
    w_next      = r_state;
    w_err_next  = r_err;
    w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                  (r_state == S_MEM_WRITE);
    case (r_state)
      S_FETCH:     if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EX;
          default: begin
            w_next     = S_HALT;
            w_err_next = 2'b01;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          w_next = S_MEM_READ;
        end else if (opcode == OP_SW) begin
          w_next = S_MEM_WRITE;
        end else begin
          w_next     = S_HALT;
          w_err_next = 2'b01;
        end
      end
      S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_next = S_FETCH;
      S_EXEC_R:    w_next = S_ALU_WB;
      S_ADDI_EX:   w_next = S_ADDI_WB;
      S_HALT:      w_next = S_HALT;
      default: begin
        w_next     = S_HALT;
        w_err_next = 2'b01;
      end
    endcase
    // A ready in the final allowed wait cycle still completes the access.
    if (w_mem_state && !mem_ready && (r_wait == WAIT_MAX)) begin
      w_next     = S_HALT;
      w_err_next = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_wait  <= 8'd0;
      r_err   <= 2'b00;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_next;
      if (w_next != r_state) begin
        r_wait <= 8'd0;
      end else if (w_mem_state && !mem_ready) begin
        r_wait <= r_wait + 8'd1;
      end
      if ((w_next == S_FETCH) && (r_state != S_FETCH)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:    alu_src_b = 2'b11;
        S_MEM_ADDR, S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_ADDI_WB:   reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign state       = r_state;
  assign err         = r_err;
  assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: vector table, hand-written corner sequences
// and randomized stimulus against an instruction-path reference model.
`default_nettype none

module tb_mips_multicycle_ctrl;

  localparam int MAXW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source, err;
  logic [3:0]  state;
  logic [31:0] instr_count;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(MAXW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  wire [15:0] act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                          alu_src_b, alu_op, pc_source};

  // Reference model: an instruction is FETCH, DECODE, then a list of states
  // looked up from the opcode; the memory states wait on ready.
  int          m_state = 0;
  int          m_wait  = 0;
  int          m_err   = 0;
  logic [31:0] m_cnt   = 0;
  int          m_q[$];

  function automatic logic [15:0] ctrl_of(int st, logic rdy);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  function automatic void model_advance();
    m_wait = 0;
    if (m_state == 0) m_state = 1;
    else if (m_q.size() == 0) begin
      m_state = 0;
      m_cnt   = m_cnt + 1;
    end else m_state = m_q.pop_front();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = 0; m_wait = 0; m_err = 0; m_cnt = 0;
      m_q.delete();
    end else if (m_state != 12) begin
      if (m_state == 0 || m_state == 3 || m_state == 5) begin
        if (mem_ready) model_advance();
        else if (m_wait == MAXW) begin m_state = 12; m_err = 2; end
        else m_wait = m_wait + 1;
      end else if (m_state == 1) begin
        m_q.delete();
        case (opcode)
          6'h00: m_q = '{6, 7};
          6'h23: m_q = '{2, 3, 4};
          6'h2B: m_q = '{2, 5};
          6'h04: m_q = '{8};
          6'h02: m_q = '{9};
          6'h08: m_q = '{10, 11};
          default: ;
        endcase
        if (m_q.size() == 0) begin m_state = 12; m_err = 1; end
        else model_advance();
      end else model_advance();
    end
  end

  task automatic check(string name, logic [15:0] ec, int es, int ee, logic [31:0] ecnt);
    n_tests++;
    if ({state, err, instr_count, act_ctrl} !== {4'(es), 2'(ee), ecnt, ec}) begin
      n_fail++;
      $display("FAIL %s: got state=%0d err=%0d cnt=%0d ctrl=%h, expected state=%0d err=%0d cnt=%0d ctrl=%h",
               name, state, err, instr_count, act_ctrl, es, ee, ecnt, ec);
    end
  endtask

  task automatic apply(logic [5:0] op, logic rdy);
    @(negedge clk);
    rst = 1'b1; opcode = op; mem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    check("reset", 16'h0000, 0, 0, 32'd0);
    @(posedge clk);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    int          st;
    logic [15:0] ctrl;
    int          err;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic [5:0] op, logic rdy, int st, logic [15:0] ctrl,
                              int e, logic [31:0] cnt);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.err = e; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

  initial begin
    // lw, R-type with three FETCH stalls, beq, j, addi, sw
    add(6'h23, 1, 0, 16'h9410, 0, 0); add(6'h23, 1, 1, 16'h0030, 0, 0);
    add(6'h23, 1, 2, 16'h0060, 0, 0); add(6'h23, 1, 3, 16'h3000, 0, 0);
    add(6'h23, 1, 4, 16'h0280, 0, 0);
    add(6'h00, 0, 0, 16'h1010, 0, 1); add(6'h00, 0, 0, 16'h1010, 0, 1);
    add(6'h00, 0, 0, 16'h1010, 0, 1); add(6'h00, 1, 0, 16'h9410, 0, 1);
    add(6'h00, 0, 1, 16'h0030, 0, 1); add(6'h00, 0, 6, 16'h0048, 0, 1);
    add(6'h00, 1, 7, 16'h0180, 0, 1);
    add(6'h04, 1, 0, 16'h9410, 0, 2); add(6'h04, 0, 1, 16'h0030, 0, 2);
    add(6'h04, 0, 8, 16'h4045, 0, 2);
    add(6'h02, 1, 0, 16'h9410, 0, 3); add(6'h02, 1, 1, 16'h0030, 0, 3);
    add(6'h02, 1, 9, 16'h8002, 0, 3);
    add(6'h08, 1, 0, 16'h9410, 0, 4); add(6'h08, 1, 1, 16'h0030, 0, 4);
    add(6'h08, 1, 10, 16'h0060, 0, 4); add(6'h08, 1, 11, 16'h0080, 0, 4);
    add(6'h2B, 1, 0, 16'h9410, 0, 5); add(6'h2B, 1, 1, 16'h0030, 0, 5);
    add(6'h2B, 1, 2, 16'h0060, 0, 5); add(6'h2B, 1, 5, 16'h2800, 0, 5);
    add(6'h00, 0, 0, 16'h1010, 0, 6);

    do_reset();
    foreach (tbl[i]) begin
      apply(tbl[i].op, tbl[i].rdy);
      check($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].st, tbl[i].err, tbl[i].cnt);
    end

    // Illegal opcode halts and freezes everything
    apply(6'h3F, 1); check("ill_fetch", 16'h9410, 0, 0, 6);
    apply(6'h3F, 1); check("ill_decode", 16'h0030, 1, 0, 6);
    for (int k = 0; k < 10; k++) begin
      apply(6'h3F, 1); check("ill_halt", 16'h0000, 12, 1, 6);
    end

    // sw timeout at the wait limit
    do_reset();
    apply(6'h2B, 1); apply(6'h2B, 1); apply(6'h2B, 1);
    check("to_addr", 16'h0060, 2, 0, 0);
    for (int k = 0; k <= MAXW; k++) begin
      apply(6'h2B, 0); check("to_wait", 16'h2800, 5, 0, 0);
    end
    apply(6'h2B, 0); check("to_halt", 16'h0000, 12, 2, 0);

    // ready in the final allowed cycle wins
    do_reset();
    apply(6'h2B, 1); apply(6'h2B, 1); apply(6'h2B, 1);
    for (int k = 0; k < MAXW; k++) apply(6'h2B, 0);
    apply(6'h2B, 1); check("rw_last", 16'h2800, 5, 0, 0);
    apply(6'h2B, 0); check("rw_fetch", 16'h1010, 0, 0, 1);

    // Asynchronous reset in the middle of MEM_READ
    do_reset();
    apply(6'h04, 1); apply(6'h04, 1); apply(6'h04, 1);
    apply(6'h23, 1); apply(6'h23, 1); apply(6'h23, 1);
    apply(6'h23, 0); check("ar_memrd", 16'h3000, 3, 0, 1);
    #2 rst = 1'b0;
    #1 check("ar_now", 16'h0000, 0, 0, 0);
    @(posedge clk);
    apply(6'h23, 1); check("ar_fetch", 16'h9410, 0, 0, 0);
    apply(6'h23, 1); check("ar_decode", 16'h0030, 1, 0, 0);

    // Randomized run against the model
    do_reset();
    begin
      logic [5:0] cur_op;
      int halt_cycles;
      cur_op = 6'h00;
      halt_cycles = 0;
      for (int n = 0; n < 3000; n++) begin
        if (m_state == 12) halt_cycles++;
        else halt_cycles = 0;
        if (halt_cycles > 3) begin
          do_reset();
          halt_cycles = 0;
        end
        if (m_state == 0) begin
          if ($urandom_range(0, 19) == 0) cur_op = 6'($urandom_range(0, 63));
          else cur_op = legal_ops[$urandom_range(0, 5)];
        end
        apply(cur_op, ($urandom_range(0, 3) != 0));
        check("rand", ctrl_of(m_state, mem_ready), m_state, m_err, m_cnt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
